// File: rtl/stream_extrema_tracker_pkg.sv
// Shared types and constants for the stream extrema tracker and its comparator.
package stream_extrema_tracker_pkg;

   localparam int DATA_W = 4;

   typedef enum logic {
      COLLECT = 1'b0,
      REPORT  = 1'b1
   } state_e;

endpackage

// File: rtl/stream_extrema_tracker_comparator.sv
// Unsigned magnitude comparator: flags A>B, A<B and A==B.
module numerical_comparator
   import stream_extrema_tracker_pkg::*;
(
   input  logic [DATA_W-1:0] A,
   input  logic [DATA_W-1:0] B,
   output logic              Fmax,
   output logic              Fmin,
   output logic              Fequ
);

   assign Fmax = (A > B);
   assign Fmin = (A < B);
   assign Fequ = (A == B);

endmodule

// File: rtl/stream_extrema_tracker.sv
// Groups a 4-bit sample stream into windows and reports max/min, their
// occurrence counts and the window length over a valid/ready handshake.
module stream_extrema_tracker
   import stream_extrema_tracker_pkg::*;
#(
   parameter  int WINDOW = 8,
   localparam int CNT_W  = $clog2(WINDOW + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_max,
   output logic [DATA_W-1:0] out_min,
   output logic [CNT_W-1:0]  out_max_cnt,
   output logic [CNT_W-1:0]  out_min_cnt,
   output logic [CNT_W-1:0]  out_len
);

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    len_q, len_d;
   logic [DATA_W-1:0]   max_q, max_d, min_q, min_d;
   logic [CNT_W-1:0]    max_cnt_q, max_cnt_d, min_cnt_q, min_cnt_d;
   logic [DATA_W-1:0]   out_max_q, out_max_d, out_min_q, out_min_d;
   logic [CNT_W-1:0]    out_max_cnt_q, out_max_cnt_d, out_min_cnt_q, out_min_cnt_d;
   logic [CNT_W-1:0]    out_len_q, out_len_d;
   logic                out_valid_q, out_valid_d;

   logic                accept;
   logic                max_gt, max_lt, max_eq;
   logic                min_gt, min_lt, min_eq;

   numerical_comparator u_cmp_max (
      .A    (in_data),
      .B    (max_q),
      .Fmax (max_gt),
      .Fmin (max_lt),
      .Fequ (max_eq)
   );

   numerical_comparator u_cmp_min (
      .A    (in_data),
      .B    (min_q),
      .Fmax (min_gt),
      .Fmin (min_lt),
      .Fequ (min_eq)
   );

   assign in_ready = (state_q == COLLECT);
   assign accept   = in_valid && in_ready;

   always_comb begin
      state_d       = state_q;
      len_d         = len_q;
      max_d         = max_q;
      min_d         = min_q;
      max_cnt_d     = max_cnt_q;
      min_cnt_d     = min_cnt_q;
      out_max_d     = out_max_q;
      out_min_d     = out_min_q;
      out_max_cnt_d = out_max_cnt_q;
      out_min_cnt_d = out_min_cnt_q;
      out_len_d     = out_len_q;
      out_valid_d   = out_valid_q;

      case (state_q)
         COLLECT: begin
            if (accept) begin
               if (len_q == '0) begin
                  max_d     = in_data;
                  min_d     = in_data;
                  max_cnt_d = CNT_W'(1);
                  min_cnt_d = CNT_W'(1);
               end else begin
                  case ({max_gt, max_eq, max_lt})
                     3'b100: begin
                        max_d     = in_data;
                        max_cnt_d = CNT_W'(1);
                     end
                     3'b010:  max_cnt_d = max_cnt_q + CNT_W'(1);
                     default: ;
                  endcase
                  case ({min_lt, min_eq, min_gt})
                     3'b100: begin
                        min_d     = in_data;
                        min_cnt_d = CNT_W'(1);
                     end
                     3'b010:  min_cnt_d = min_cnt_q + CNT_W'(1);
                     default: ;
                  endcase
               end
               len_d = len_q + CNT_W'(1);
            end
            // Closing snapshot uses the working values already updated with this cycle's sample.
            if ((accept && (len_q == CNT_W'(WINDOW - 1))) ||
                (flush && ((len_q != '0) || accept))) begin
               out_max_d     = max_d;
               out_min_d     = min_d;
               out_max_cnt_d = max_cnt_d;
               out_min_cnt_d = min_cnt_d;
               out_len_d     = len_d;
               out_valid_d   = 1'b1;
               state_d       = REPORT;
            end
         end
         REPORT: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               len_d       = '0;
               state_d     = COLLECT;
            end
         end
         default: state_d = COLLECT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= COLLECT;
         len_q         <= '0;
         max_q         <= '0;
         min_q         <= '0;
         max_cnt_q     <= '0;
         min_cnt_q     <= '0;
         out_max_q     <= '0;
         out_min_q     <= '0;
         out_max_cnt_q <= '0;
         out_min_cnt_q <= '0;
         out_len_q     <= '0;
         out_valid_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         len_q         <= len_d;
         max_q         <= max_d;
         min_q         <= min_d;
         max_cnt_q     <= max_cnt_d;
         min_cnt_q     <= min_cnt_d;
         out_max_q     <= out_max_d;
         out_min_q     <= out_min_d;
         out_max_cnt_q <= out_max_cnt_d;
         out_min_cnt_q <= out_min_cnt_d;
         out_len_q     <= out_len_d;
         out_valid_q   <= out_valid_d;
      end
   end

   assign out_valid   = out_valid_q;
   assign out_max     = out_max_q;
   assign out_min     = out_min_q;
   assign out_max_cnt = out_max_cnt_q;
   assign out_min_cnt = out_min_cnt_q;
   assign out_len     = out_len_q;

endmodule

// File: tb/tb_stream_extrema_tracker.sv
// Self-checking bench for stream_extrema_tracker: vector table, corner sequences, random windows vs model.
module tb_stream_extrema_tracker;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [3:0] in_data = 4'd0;
   logic       flush = 1'b0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [3:0] out_max, out_min, out_max_cnt, out_min_cnt, out_len;

   int checks = 0;
   int failures = 0;

   typedef struct packed {
      logic [31:0] s;      // sample i in bits [4*i+3:4*i]
      logic [3:0]  n;
      logic [1:0]  mode;   // 0: close by count, 1: flush with last sample, 2: flush afterwards
      logic [3:0]  emax;
      logic [3:0]  emin;
      logic [3:0]  emaxc;
      logic [3:0]  eminc;
      logic [3:0]  elen;
   } vec_t;

   vec_t tbl [8];

   stream_extrema_tracker #(.WINDOW(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .flush       (flush),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_max     (out_max),
      .out_min     (out_min),
      .out_max_cnt (out_max_cnt),
      .out_min_cnt (out_min_cnt),
      .out_len     (out_len)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic drive_cycle(input logic v, input logic [3:0] d, input logic f);
      in_valid = v;
      in_data  = d;
      flush    = f;
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(input logic [31:0] s, input int n, input int mode,
                               input int mx, input int mn, input int mxc, input int mnc, input int len);
      vec_t v;
      v.s = s; v.n = 4'(n); v.mode = 2'(mode);
      v.emax = 4'(mx); v.emin = 4'(mn); v.emaxc = 4'(mxc); v.eminc = 4'(mnc); v.elen = 4'(len);
      return v;
   endfunction

   // Reference: extremes and counts straight from the list of samples.
   task automatic model(input logic [31:0] s, input int n,
                        output logic [3:0] mx, output logic [3:0] mn,
                        output logic [3:0] mxc, output logic [3:0] mnc);
      logic [3:0] v;
      mx = s[3:0];
      mn = s[3:0];
      for (int i = 0; i < n; i++) begin
         v = s[4*i +: 4];
         if (v > mx) mx = v;
         if (v < mn) mn = v;
      end
      mxc = 0;
      mnc = 0;
      for (int i = 0; i < n; i++) begin
         v = s[4*i +: 4];
         if (v == mx) mxc++;
         if (v == mn) mnc++;
      end
   endtask

   task automatic check_result(input string tag, input logic [3:0] emax, input logic [3:0] emin,
                               input logic [3:0] emaxc, input logic [3:0] eminc, input logic [3:0] elen);
      check({tag, ".max"},     out_max,     emax);
      check({tag, ".min"},     out_min,     emin);
      check({tag, ".max_cnt"}, out_max_cnt, emaxc);
      check({tag, ".min_cnt"}, out_min_cnt, eminc);
      check({tag, ".len"},     out_len,     elen);
   endtask

   task automatic run_window(input string tag, input logic [31:0] s, input int n, input int mode,
                             input int delay, input bit gaps,
                             input logic [3:0] emax, input logic [3:0] emin,
                             input logic [3:0] emaxc, input logic [3:0] eminc, input logic [3:0] elen);
      for (int i = 0; i < n; i++) begin
         if (gaps && ($urandom % 3 == 0)) drive_cycle(1'b0, 4'd0, 1'b0);
         if (i == n - 1) check({tag, ".early_valid"}, out_valid, 1'b0);
         drive_cycle(1'b1, s[4*i +: 4], (mode == 1) && (i == n - 1));
      end
      if (mode == 2) begin
         in_valid = 1'b0;
         check({tag, ".pre_flush_valid"}, out_valid, 1'b0);
         drive_cycle(1'b0, 4'd0, 1'b1);
      end
      in_valid = 1'b0;
      flush    = 1'b0;
      check({tag, ".valid"}, out_valid, 1'b1);
      check({tag, ".in_ready"}, in_ready, 1'b0);
      check_result(tag, emax, emin, emaxc, eminc, elen);
      for (int d = 0; d < delay; d++) begin
         @(posedge clk);
         #1;
         check({tag, ".hold_valid"}, out_valid, 1'b1);
         check({tag, ".hold_max"}, out_max, emax);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check({tag, ".valid_drop"}, out_valid, 1'b0);
      check({tag, ".persist_max"}, out_max, emax);
      check({tag, ".persist_len"}, out_len, elen);
   endtask

   initial begin
      logic [31:0] s;
      logic [3:0]  mx, mn, mxc, mnc;
      int          n, mode;

      tbl[0] = mk(32'h0507_7273, 8, 0,  7,  0, 3, 2, 8);
      tbl[1] = mk(32'h0000_0999, 3, 2,  9,  9, 3, 3, 3);
      tbl[2] = mk(32'h0000_0F40, 3, 1, 15,  0, 1, 1, 3);
      tbl[3] = mk(32'h0000_0006, 1, 1,  6,  6, 1, 1, 1);
      tbl[4] = mk(32'h1234_5678, 8, 0,  8,  1, 1, 1, 8);
      tbl[5] = mk(32'hFFFF_FFFF, 8, 0, 15, 15, 8, 8, 8);
      tbl[6] = mk(32'h0000_0000, 2, 2,  0,  0, 2, 2, 2);
      tbl[7] = mk(32'h0765_4321, 7, 2,  7,  1, 1, 1, 7);

      // Reset state
      #2;
      check("rst.out_valid", out_valid, 1'b0);
      check("rst.in_ready", in_ready, 1'b1);
      check("rst.out_max", out_max, 4'd0);
      check("rst.out_len", out_len, 4'd0);
      #10;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int t = 0; t < 8; t++) begin
         run_window($sformatf("vec%0d", t), tbl[t].s, int'(tbl[t].n), int'(tbl[t].mode), t % 3, 1'b0,
                    tbl[t].emax, tbl[t].emin, tbl[t].emaxc, tbl[t].eminc, tbl[t].elen);
      end

      // Flush with nothing collected never produces a window
      for (int k = 0; k < 3; k++) begin
         drive_cycle(1'b0, 4'd0, 1'b1);
         check("empty_flush.valid", out_valid, 1'b0);
      end
      flush = 1'b0;

      // Backpressure: sample pending while the result waits
      for (int i = 0; i < 8; i++) drive_cycle(1'b1, (i == 3) ? 4'd12 : 4'd4, 1'b0);
      in_valid = 1'b1;
      in_data  = 4'hA;
      for (int k = 0; k < 5; k++) begin
         flush = (k == 2);
         check("bp.in_ready", in_ready, 1'b0);
         check("bp.valid", out_valid, 1'b1);
         check_result("bp", 4'd12, 4'd4, 4'd1, 4'd7, 4'd8);
         @(posedge clk);
         #1;
      end
      flush = 1'b0;
      check_result("bp_after_flush", 4'd12, 4'd4, 4'd1, 4'd7, 4'd8);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("bp.released_valid", out_valid, 1'b0);
      check("bp.bubble_ready", in_ready, 1'b1);
      run_window("bp_next", 32'h3333_333A, 8, 0, 0, 1'b0, 4'hA, 4'd3, 4'd1, 4'd7, 4'd8);

      // Reset in the middle of a window discards it
      for (int i = 0; i < 4; i++) drive_cycle(1'b1, 4'd9, 1'b0);
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check("midrst.valid", out_valid, 1'b0);
      check("midrst.max", out_max, 4'd0);
      check("midrst.len", out_len, 4'd0);
      check("midrst.in_ready", in_ready, 1'b1);
      #3;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      run_window("post_rst", 32'h5555_5555, 8, 0, 1, 1'b0, 4'd5, 4'd5, 4'd8, 4'd8, 4'd8);

      // Reset while a result is pending
      for (int i = 0; i < 8; i++) drive_cycle(1'b1, 4'd2, 1'b0);
      in_valid = 1'b0;
      check("pend.valid", out_valid, 1'b1);
      rst_n = 1'b0;
      #1;
      check("pend_rst.valid", out_valid, 1'b0);
      check("pend_rst.cnt", out_max_cnt, 4'd0);
      #3;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Random windows against the reference model
      for (int r = 0; r < 40; r++) begin
         n = int'($urandom_range(1, 8));
         mode = (n == 8) ? int'($urandom % 2) : 1 + int'($urandom % 2);
         s = '0;
         for (int i = 0; i < n; i++)
            s[4*i +: 4] = (r % 2 == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
         model(s, n, mx, mn, mxc, mnc);
         run_window($sformatf("rand%0d", r), s, n, mode, int'($urandom_range(0, 3)), 1'b1,
                    mx, mn, mxc, mnc, 4'(n));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/stream_extrema_tracker.md
Name: stream_extrema_tracker

Overview:
- Downstream consumer of the 4-bit magnitude comparator.
- Accepts a stream of 4-bit unsigned samples over a valid/ready handshake and groups them into windows of WINDOW samples, or fewer if flushed early.
- For each window it tracks the maximum, the minimum, how many times each extreme value occurred, and the window length.
- Presents the per-window result on an output valid/ready handshake to the next stage (threshold/alarm logic).

Parameters:
- WINDOW, 8, samples per window; legal range 2..255.
- CNT_W, $clog2(WINDOW+1), width of the length and occurrence counters; derived, not overridden.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  block can accept a sample this cycle.
- in_data  input  4  unsigned sample.
- flush  input  1  close the current window early.
- out_valid  output  1  result registers hold a completed window.
- out_ready  input  1  consumer takes the result this cycle.
- out_max  output  4  largest sample in the window.
- out_min  output  4  smallest sample in the window.
- out_max_cnt  output  CNT_W  number of samples equal to out_max.
- out_min_cnt  output  CNT_W  number of samples equal to out_min.
- out_len  output  CNT_W  number of samples in the window.

Behaviour:
- Reset: asynchronous and active-low; one clock (clk).
  - All registers clear asynchronously: state=COLLECT, len=0, out_valid=0, out_max/out_min/out_max_cnt/out_min_cnt/out_len=0.
  - in_ready = (state==COLLECT), so it is 1 immediately after reset.
- Sample accept: in_valid & in_ready on a rising edge.
- States: COLLECT and REPORT.
- COLLECT, accept with len==0:
  - max=min=in_data, max_cnt=min_cnt=1, len=1.
- COLLECT, accept with len>0: in_data is compared against max and against min, using two comparator instances.
  - Greater than max: max=in_data, max_cnt=1.
  - Equal to max: max_cnt+1.
  - Less than max: max unchanged.
  - Min is handled symmetrically: less than min replaces min and sets min_cnt=1; equal increments min_cnt.
  - A sample equal to both max and min updates both counts.
  - len+1.
- Window close: accept while len==WINDOW-1, or flush=1 while (len>0 or an accept occurs this cycle).
  - The accepted sample is included in the result.
  - Working values, updated with that sample, are copied into the out_* registers.
  - Next state is REPORT with out_valid=1.
- flush=1 with len==0 and no accept is ignored; no empty window is ever reported.
- REPORT:
  - in_ready=0; flush is ignored.
  - out_* values are held stable while out_valid=1.
  - On out_valid & out_ready: out_valid goes to 0, len clears to 0, next state is COLLECT.
  - There is a one-cycle bubble before the next sample is accepted; no bypass path.
- Latency: the result is visible one cycle after the closing accept or flush edge.
- Counters never exceed WINDOW, so no saturation logic is required.
- out_* values persist after a handshake until the next window closes.
- Reset asserted mid-window or in REPORT: the partial window or pending result is discarded and no output is produced.

Decomposition:
- Shared package:
  - State enum {COLLECT, REPORT}.
  - Constant DATA_W=4 (fixed by the comparator width).
- Sub-module: numerical_comparator (ports A, B, Fmax, Fmin, Fequ), instantiated twice:
  - in_data vs max;
  - in_data vs min.
- No other sub-modules.

Test Plan:
- WINDOW=8; stream 3,7,2,7,7,0,5,0 with no backpressure -> out_max=7, out_max_cnt=3, out_min=0, out_min_cnt=2, out_len=8; out_valid asserted one cycle after the 8th accept.
- Samples 9,9,9 then flush=1 with no valid -> out_max=out_min=9, both counts=3, out_len=3.
- flush=1 with the same-cycle sample 15 after 0,4 -> out_max=15/cnt 1, out_min=0/cnt 1, out_len=3.
- flush with len==0 -> out_valid stays 0.
- Complete a window, then hold out_ready=0 for 5 cycles while in_valid=1:
  - in_ready=0 throughout, out_* stable, no sample lost;
  - after out_ready=1, the next window starts with the pending sample.
- Deassert rst_n after 4 samples of a window -> outputs and out_valid immediately 0; a following 8-sample window of all 0x5 reports max=min=5, both counts=8, len=8.
